peripheral_msi_slave_port_ahb3: RTL and testbench
=================================================

Name: peripheral_msi_slave_port_ahb3

Overview:
Per-slave arbitration stage of the AHB3 multi-layer interconnect. It sits directly downstream of the per-master MSI master ports. It consumes each master port's slave-select, priority, can_switch and address/data-phase signals, and returns a one-hot master_granted. It drives a single AHB-Lite slave from the granted master.
- Arbitration is priority-based, with a tie-break among equal priorities.
- Ownership changes only when the current owner's master port indicates it may switch.

Parameters:
PLEN, 64, address width
XLEN, 64, data width
MASTERS, 5, number of master ports feeding this slave
MASTER_BITS, $clog2(MASTERS) (min 1), owner index width

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
mstpriority  in  [MASTERS][3]  per-master priority, 7 = highest
mstHSEL  in  [MASTERS]  master port requests this slave (that master port's slvHSEL bit for this slave)
mstHADDR  in  [MASTERS][PLEN]  address-phase address
mstHWDATA  in  [MASTERS][XLEN]  data-phase write data
mstHWRITE  in  [MASTERS]  write
mstHSIZE  in  [MASTERS][3]  size
mstHBURST  in  [MASTERS][3]  burst
mstHPROT  in  [MASTERS][4]  protection
mstHTRANS  in  [MASTERS][2]  transfer type
mstHMASTLOCK  in  [MASTERS]  lock
mstHREADY  in  [MASTERS]  master port's slvHREADYOUT
can_switch  in  [MASTERS]  owner may be replaced next cycle
master_granted  out  [MASTERS]  one-hot grant, registered
slv_HSEL  out  1  slave select
slv_HADDR  out  PLEN  muxed address
slv_HWDATA  out  XLEN  muxed write data (data-phase owner)
slv_HWRITE  out  1  muxed write
slv_HSIZE  out  3  muxed size
slv_HBURST  out  3  muxed burst
slv_HPROT  out  4  muxed protection
slv_HTRANS  out  2  muxed transfer type
slv_HMASTLOCK  out  1  muxed lock
slv_HREADY  out  1  HREADY to slave
slv_HREADYOUT  in  1  slave's ready (returned to master ports via their slvHREADY)

Behaviour:
Reset (HRESETn low at a posedge):
- master_granted=0, owner_valid=0, owner=0, data_owner=0.
- Outputs then: slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADY=1.

State:
- owner: MASTER_BITS register.
- owner_valid: flag.
- data_owner: register.
- master_granted = owner_valid ? onehot(owner) : 0.

Arbitration request set:
- req = mstHSEL.
- Winner = highest mstpriority among req bits; equal-priority tie-break per the Optional Feature.

Re-arbitration condition, sampled at each posedge:
- Condition: (!owner_valid | can_switch[owner] | !mstHSEL[owner]) & slv_HREADYOUT.
- If true and |req: owner <= winner, owner_valid <= 1.
- If true and req==0: owner_valid <= 0.
- Otherwise hold.
- A locked owner blocks switching because its master port holds can_switch low.

Grant latency:
- Request is granted exactly 1 cycle after mstHSEL rises when the slave is idle and ready.
- While slv_HREADYOUT is low, the grant never changes.

Address-phase mux:
- When owner_valid, outputs are the owner's inputs: slv_HSEL = mstHSEL[owner], and HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK from the owner.
- slv_HREADY = mstHREADY[owner].
- When !owner_valid: slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADY=1, other outputs 0.

Data phase:
- data_owner <= owner at each posedge where slv_HREADYOUT=1.
- slv_HWDATA = mstHWDATA[data_owner].
- This keeps write data aligned after an ownership switch.

Simultaneous events:
- Owner drops mstHSEL while another master requests in the same cycle → switch (still gated by slv_HREADYOUT).
- New higher-priority request while owner's can_switch=0 → stays pending, no grant.
- mstHSEL bits with no grant produce no slave activity.

Mid-operation reset clears the grant and ownership at the next edge regardless of slave ready.

Optional Feature:
Macro MSI_SLV_ROUND_ROBIN_EN.
- Defined: equal-priority ties are resolved round-robin. Search starts at last_owner+1, modulo MASTERS, and wraps. last_owner is a register updated on every grant change and reset to MASTERS-1, so the first tie goes to master 0.
- Undefined: equal-priority ties go to the lowest index; no last_owner register.

Test Plan:
- Reset, then mstHSEL[2]=1 with priority 3 and slv_HREADYOUT=1 → master_granted=5'b00100 one cycle later; slv_HADDR = mstHADDR[2].
- Masters 1 (priority 2) and 3 (priority 5) request together → master_granted=5'b01000; after can_switch[3]=1 and mstHSEL[3]=0, next cycle master_granted=5'b00010.
- Owner 0 has mstHMASTLOCK=1 and can_switch[0]=0; master 4 requests at priority 7 → grant stays 5'b00001 for 10 cycles, then switches 1 cycle after can_switch[0]=1.
- slv_HREADYOUT=0 for 3 cycles during an owner switch request → grant unchanged for those cycles; slv_HWDATA follows data_owner, not owner, in the first cycle after the switch.
- With MSI_SLV_ROUND_ROBIN_EN defined, masters 0, 1 and 2 all request at priority 4 and each asserts can_switch → grants rotate 0→1→2→0. With the macro undefined → master 0 is re-granted every time.
- HRESETn low for 1 cycle mid-burst → next cycle master_granted=0, slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADY=1.

Source files
------------

// File: rtl/peripheral_msi_slave_port_ahb3.sv
// Per-slave arbitration stage of the AHB3 multi-layer interconnect: picks an owner among the
// master ports by priority and drives one AHB-Lite slave. Optional macro MSI_SLV_ROUND_ROBIN_EN.
`default_nettype none

module peripheral_msi_slave_port_ahb3 #(
    parameter int PLEN        = 64,
    parameter int XLEN        = 64,
    parameter int MASTERS     = 5,
    parameter int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,

    input  logic [MASTERS-1:0][2:0]         mstpriority,
    input  logic [MASTERS-1:0]              mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0]    mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0]    mstHWDATA,
    input  logic [MASTERS-1:0]              mstHWRITE,
    input  logic [MASTERS-1:0][2:0]         mstHSIZE,
    input  logic [MASTERS-1:0][2:0]         mstHBURST,
    input  logic [MASTERS-1:0][3:0]         mstHPROT,
    input  logic [MASTERS-1:0][1:0]         mstHTRANS,
    input  logic [MASTERS-1:0]              mstHMASTLOCK,
    input  logic [MASTERS-1:0]              mstHREADY,
    input  logic [MASTERS-1:0]              can_switch,
    output logic [MASTERS-1:0]              master_granted,

    output logic                            slv_HSEL,
    output logic [PLEN-1:0]                 slv_HADDR,
    output logic [XLEN-1:0]                 slv_HWDATA,
    output logic                            slv_HWRITE,
    output logic [2:0]                      slv_HSIZE,
    output logic [2:0]                      slv_HBURST,
    output logic [3:0]                      slv_HPROT,
    output logic [1:0]                      slv_HTRANS,
    output logic                            slv_HMASTLOCK,
    output logic                            slv_HREADY,
    input  logic                            slv_HREADYOUT
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [MASTER_BITS-1:0] owner_q, owner_d;
    logic                   owner_valid_q, owner_valid_d;
    logic [MASTER_BITS-1:0] data_owner_q, data_owner_d;
    logic [MASTER_BITS-1:0] winner;
    logic                   rearb;

`ifdef MSI_SLV_ROUND_ROBIN_EN
    logic [MASTER_BITS-1:0] last_owner_q, last_owner_d;

    // Scan in rotation order starting after the last owner; strict '>' keeps the first hit on ties.
    always_comb begin
        int                     idx;
        logic                   found;
        logic [2:0]             best;
        logic [MASTER_BITS-1:0] sel;
        winner = '0;
        found  = 1'b0;
        best   = '0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < MASTERS; k++) begin
            idx = int'(last_owner_q) + 1 + k;
            if (idx >= MASTERS) idx = idx - MASTERS;
            if (idx >= MASTERS) idx = idx - MASTERS;
            sel = MASTER_BITS'(idx);
            if (mstHSEL[sel] && (!found || (mstpriority[sel] > best))) begin
                winner = sel;
                best   = mstpriority[sel];
                found  = 1'b1;
            end
        end
    end
`else
    // Ascending scan with strict '>' hands ties to the lowest index.
    always_comb begin
        logic       found;
        logic [2:0] best;
        winner = '0;
        found  = 1'b0;
        best   = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (mstHSEL[i] && (!found || (mstpriority[i] > best))) begin
                winner = MASTER_BITS'(i);
                best   = mstpriority[i];
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        rearb = (!owner_valid_q || can_switch[owner_q] || !mstHSEL[owner_q]) && slv_HREADYOUT;

        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        data_owner_d  = slv_HREADYOUT ? owner_q : data_owner_q;
`ifdef MSI_SLV_ROUND_ROBIN_EN
        last_owner_d  = last_owner_q;
`endif
        if (rearb) begin
            if (|mstHSEL) begin
                owner_d       = winner;
                owner_valid_d = 1'b1;
`ifdef MSI_SLV_ROUND_ROBIN_EN
                last_owner_d  = winner;
`endif
            end else begin
                owner_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            data_owner_q  <= '0;
`ifdef MSI_SLV_ROUND_ROBIN_EN
            // MASTERS-1 so the very first tie goes to master 0.
            last_owner_q  <= MASTER_BITS'(MASTERS - 1);
`endif
        end else begin
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            data_owner_q  <= data_owner_d;
`ifdef MSI_SLV_ROUND_ROBIN_EN
            last_owner_q  <= last_owner_d;
`endif
        end
    end

    always_comb begin
        master_granted = '0;
        if (owner_valid_q) master_granted[owner_q] = 1'b1;
    end

    // Address phase follows the current owner; write data follows the owner of the previous address phase.
    always_comb begin
        slv_HSEL      = 1'b0;
        slv_HADDR     = '0;
        slv_HWRITE    = 1'b0;
        slv_HSIZE     = '0;
        slv_HBURST    = '0;
        slv_HPROT     = '0;
        slv_HTRANS    = HTRANS_IDLE;
        slv_HMASTLOCK = 1'b0;
        slv_HREADY    = 1'b1;
        if (owner_valid_q) begin
            slv_HSEL      = mstHSEL[owner_q];
            slv_HADDR     = mstHADDR[owner_q];
            slv_HWRITE    = mstHWRITE[owner_q];
            slv_HSIZE     = mstHSIZE[owner_q];
            slv_HBURST    = mstHBURST[owner_q];
            slv_HPROT     = mstHPROT[owner_q];
            slv_HTRANS    = mstHTRANS[owner_q];
            slv_HMASTLOCK = mstHMASTLOCK[owner_q];
            slv_HREADY    = mstHREADY[owner_q];
        end
    end

    assign slv_HWDATA = mstHWDATA[data_owner_q];

endmodule

`default_nettype wire

// File: tb/tb_peripheral_msi_slave_port_ahb3.sv
// Directed bench for peripheral_msi_slave_port_ahb3 with the default 5-master, 64-bit build.
module tb_peripheral_msi_slave_port_ahb3;

    localparam int M = 5;

    logic                 HCLK = 1'b0;
    logic                 HRESETn;
    logic [M-1:0][2:0]    mstpriority;
    logic [M-1:0]         mstHSEL;
    logic [M-1:0][63:0]   mstHADDR;
    logic [M-1:0][63:0]   mstHWDATA;
    logic [M-1:0]         mstHWRITE;
    logic [M-1:0][2:0]    mstHSIZE;
    logic [M-1:0][2:0]    mstHBURST;
    logic [M-1:0][3:0]    mstHPROT;
    logic [M-1:0][1:0]    mstHTRANS;
    logic [M-1:0]         mstHMASTLOCK;
    logic [M-1:0]         mstHREADY;
    logic [M-1:0]         can_switch;
    logic [M-1:0]         master_granted;
    logic                 slv_HSEL;
    logic [63:0]          slv_HADDR;
    logic [63:0]          slv_HWDATA;
    logic                 slv_HWRITE;
    logic [2:0]           slv_HSIZE;
    logic [2:0]           slv_HBURST;
    logic [3:0]           slv_HPROT;
    logic [1:0]           slv_HTRANS;
    logic                 slv_HMASTLOCK;
    logic                 slv_HREADY;
    logic                 slv_HREADYOUT;

    int passed = 0;
    int total  = 0;

    always #5 HCLK = ~HCLK;

    peripheral_msi_slave_port_ahb3 #(.PLEN(64), .XLEN(64), .MASTERS(M)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
        .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
        .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY), .can_switch(can_switch),
        .master_granted(master_granted),
        .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
        .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
        .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
        .slv_HREADY(slv_HREADY), .slv_HREADYOUT(slv_HREADYOUT)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [M-1:0] tie_exp [4];
`ifdef MSI_SLV_ROUND_ROBIN_EN
        tie_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b00001};
`else
        tie_exp = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif
        HRESETn = 1'b0;
        mstpriority = '0; mstHSEL = '0; mstHWRITE = '0; mstHSIZE = '0; mstHBURST = '0;
        mstHPROT = '0; mstHTRANS = '0; mstHMASTLOCK = '0; mstHREADY = '1; can_switch = '0;
        slv_HREADYOUT = 1'b1;
        for (int i = 0; i < M; i++) begin
            mstHADDR[i]  = 64'hA000_0000_0000_0000 + 64'(i);
            mstHWDATA[i] = 64'hD000_0000_0000_0000 + 64'(i);
        end
        tick(); tick();
        chk("rst_grant", 64'(master_granted), 64'h0);
        chk("rst_hsel", 64'(slv_HSEL), 64'h0);
        chk("rst_htrans", 64'(slv_HTRANS), 64'h0);
        chk("rst_hready", 64'(slv_HREADY), 64'h1);
        HRESETn = 1'b1;
        tick();

        // Single request: granted one cycle later.
        mstHSEL[2] = 1'b1; mstpriority[2] = 3'd3; mstHTRANS[2] = 2'b10; mstHWRITE[2] = 1'b1;
        #1;
        chk("single_pre", 64'(master_granted), 64'h0);
        tick();
        chk("single_grant", 64'(master_granted), 64'b00100);
        chk("single_haddr", slv_HADDR, 64'hA000_0000_0000_0002);
        chk("single_hsel", 64'(slv_HSEL), 64'h1);
        chk("single_htrans", 64'(slv_HTRANS), 64'h2);
        chk("single_hwrite", 64'(slv_HWRITE), 64'h1);
        mstHSEL[2] = 1'b0;
        tick();
        chk("single_release", 64'(master_granted), 64'h0);

        // Priority: 3 beats 1, then 1 takes over once 3 lets go.
        mstHSEL[1] = 1'b1; mstpriority[1] = 3'd2;
        mstHSEL[3] = 1'b1; mstpriority[3] = 3'd5;
        tick();
        chk("prio_win", 64'(master_granted), 64'b01000);
        tick();
        chk("prio_hold", 64'(master_granted), 64'b01000);
        can_switch[3] = 1'b1; mstHSEL[3] = 1'b0;
        tick();
        chk("prio_switch", 64'(master_granted), 64'b00010);
        chk("prio_haddr", slv_HADDR, 64'hA000_0000_0000_0001);
        mstHSEL = '0; can_switch = '0;
        tick();
        chk("prio_idle", 64'(master_granted), 64'h0);

        // Locked owner blocks a priority-7 request until it allows switching.
        mstHSEL[0] = 1'b1; mstpriority[0] = 3'd1; mstHMASTLOCK[0] = 1'b1;
        tick();
        chk("lock_grant", 64'(master_granted), 64'b00001);
        chk("lock_hmastlock", 64'(slv_HMASTLOCK), 64'h1);
        mstHSEL[4] = 1'b1; mstpriority[4] = 3'd7;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("lock_held", 64'(master_granted), 64'b00001);
        end
        can_switch[0] = 1'b1;
        tick();
        chk("lock_release", 64'(master_granted), 64'b10000);
        mstHSEL = '0; can_switch = '0; mstHMASTLOCK = '0;
        tick();
        chk("lock_idle", 64'(master_granted), 64'h0);

        // Stalled slave freezes the grant; write data lags the address-phase owner by one beat.
        mstHSEL[1] = 1'b1; can_switch[1] = 1'b1;
        tick(); tick();
        chk("stall_owner1", 64'(master_granted), 64'b00010);
        chk("stall_wdata1", slv_HWDATA, 64'hD000_0000_0000_0001);
        mstHSEL[3] = 1'b1; slv_HREADYOUT = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_frozen", 64'(master_granted), 64'b00010);
        end
        slv_HREADYOUT = 1'b1;
        tick();
        chk("stall_switch", 64'(master_granted), 64'b01000);
        chk("stall_haddr3", slv_HADDR, 64'hA000_0000_0000_0003);
        chk("stall_wdata_lag", slv_HWDATA, 64'hD000_0000_0000_0001);
        tick();
        chk("stall_wdata3", slv_HWDATA, 64'hD000_0000_0000_0003);
        mstHSEL = '0; can_switch = '0;
        tick();
        chk("stall_idle", 64'(master_granted), 64'h0);

        // Equal-priority ties among masters 0..2.
        mstpriority[0] = 3'd4; mstpriority[1] = 3'd4; mstpriority[2] = 3'd4;
        mstHSEL = 5'b00111; can_switch = 5'b00111;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("tie_grant", 64'(master_granted), 64'(tie_exp[c]));
        end

        // Reset mid-burst with the slave stalled.
        mstHREADY = '0;
        #1;
        chk("mid_hready_pre", 64'(slv_HREADY), 64'h0);
        slv_HREADYOUT = 1'b0; HRESETn = 1'b0;
        tick();
        chk("mid_grant", 64'(master_granted), 64'h0);
        chk("mid_hsel", 64'(slv_HSEL), 64'h0);
        chk("mid_htrans", 64'(slv_HTRANS), 64'h0);
        chk("mid_hready", 64'(slv_HREADY), 64'h1);
        HRESETn = 1'b1; slv_HREADYOUT = 1'b1;
        tick();
        chk("post_rst_grant", 64'(master_granted), 64'b00001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
